seq_detector_prog: RTL and testbench
====================================

Name: seq_detector_prog

Overview:
Programmable serial bit-pattern detector. It is the parametrised successor to the fixed 11011 Mealy non-overlapping detector. It adds run-time pattern and length configuration, selectable overlapping or non-overlapping mode, a valid qualifier on the input bit, and a saturating match counter. It sits behind the top-level tt_um wrapper: ui_in bits drive bit_in, bit_valid and config, and detect goes to uo_out[0].

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2).
CNT_W, 8, width of match_count.
LEN_W, $clog2(MAX_LEN+1), width of cfg_len (derived; do not override).

Ports:
clk  input  1  rising-edge clock, single clock domain.
rst  input  1  synchronous, active-high reset.
cfg_load  input  1  one-cycle strobe; latch cfg_pattern, cfg_len and cfg_overlap.
cfg_pattern  input  MAX_LEN  pattern; bits [len-1:0] used; bit len-1 is expected first.
cfg_len  input  LEN_W  pattern length, legal range 1..MAX_LEN.
cfg_overlap  input  1  1 = overlapping detection; 0 = non-overlapping.
bit_valid  input  1  bit_in is sampled only when high.
bit_in  input  1  serial data bit.
count_clr  input  1  synchronous clear of match_count.
detect  output  1  Mealy match pulse, combinational from state and current bit.
detect_q  output  1  detect registered one cycle later (glitch-free copy).
match_count  output  CNT_W  number of detections, saturating.

Behaviour:
- Reset (rst=1 at a clk edge) has highest priority:
  - pattern = 11011, len = 5, overlap = 0 (drop-in for the old detector).
  - History and fill cleared; detect_q = 0; match_count = 0.
  - detect = 0 while rst is high.
- State:
  - hist: MAX_LEN-1 bit shift register of past valid bits, newest at LSB.
  - fill: saturating count of valid bits since the last clear, capped at len-1.
- detect = bit_valid & !cfg_load & !rst & (fill == len-1) & ({hist,bit_in}[len-1:0] == pattern[len-1:0]).
  - Zero-cycle latency: it asserts in the same cycle as the final pattern bit.
- On each valid bit with no load:
  - hist shifts left with bit_in entering the LSB.
  - fill increments, saturating at len-1.
- On detect with overlap = 0: fill is cleared to 0, so the next match needs len fresh bits. hist still shifts.
- On detect with overlap = 1: fill is unchanged, so suffix/prefix overlaps are detected.
- bit_valid = 0: state holds and detect = 0. Gaps of any length are transparent.
- cfg_load:
  - Latches the new configuration and clears hist and fill.
  - Any bit_valid in the same cycle is discarded and detect = 0.
  - The new config applies from the next cycle.
- cfg_len clamping: 0 is treated as 1; values above MAX_LEN clamp to MAX_LEN.
- len = 1: fill is always 0 (== len-1); detect = bit_valid & (bit_in == pattern[0]), in either mode.
- detect_q <= detect every cycle; it is 0 in the cycle after reset.
- match_count:
  - Increments on detect and saturates at 2^CNT_W-1.
  - When count_clr and detect coincide, the result is 1 (clear, then count).
  - count_clr alone gives 0.
- Reset mid-sequence discards partial progress. The default pattern is restored even if it was reconfigured.

Decomposition:
- Package seq_det_pkg holds:
  - DEFAULT_PATTERN = 8'b0001_1011, DEFAULT_LEN = 5, DEFAULT_OVERLAP = 1'b0.
  - A function clamp_len(len, max) implementing the clamping rule.
- Sub-module sat_counter (parameter W; ports clk, rst, clr, inc, count) implements match_count.
- The rest is a single module (config regs, hist, fill, compare).

Test Plan:
- Defaults, overlap=0, stream 1,1,0,1,1,0,1,1 (all valid) -> detect on bit 5 only; match_count = 1; detect_q high on the cycle after bit 5.
- Load pattern=11011, len=5, overlap=1, same stream -> detect on bits 5 and 8; match_count = 2.
- Defaults, stream 1,1,0,1,1 with bit_valid low for 3 cycles between each bit -> single detect on the 5th valid bit; detect stays 0 during gaps.
- Load pattern=101, len=3, overlap=0, stream 1,0,1,0,1 -> detect on bit 3 only. Then cfg_len=0 with pattern bit0=1, stream 1,0,1 -> detect on bits 1 and 3.
- CNT_W=2, overlap=1, len=1, pattern=1, six consecutive 1s -> count 1,2,3,3,3,3. Then count_clr coincident with detect -> count = 1.
- Load len=3, pattern=101, feed 1,0, assert rst, then feed 1,1,0,1,1 -> no detect after 1,0,1 spanning the reset; detect on the 5th bit after reset (default 11011 restored); match_count = 1.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
// The reset defaults reproduce the legacy fixed 11011 non-overlapping detector.
package seq_det_pkg;

  localparam logic [7:0]  DEFAULT_PATTERN = 8'b0001_1011;
  localparam int unsigned DEFAULT_LEN     = 5;
  localparam logic        DEFAULT_OVERLAP = 1'b0;

  typedef enum logic {
    MODE_DISJOINT = 1'b0,
    MODE_OVERLAP  = 1'b1
  } match_mode_e;

  // A zero length would make the compare window empty, so it is promoted to one bit.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max);
    if (len == 0) begin
      return 1;
    end else if (len > max) begin
      return max;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear.
// Clear and increment together load 1, so a detection coinciding with a clear is kept.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? W'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable Mealy serial pattern detector with run-time length, pattern and
// overlap mode, a valid qualifier on the input bit and a saturating match counter.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               bit_valid,
  input  logic               bit_in,
  input  logic               count_clr,
  output logic               detect,
  output logic               detect_q,
  output logic [CNT_W-1:0]   match_count
);

  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  match_mode_e        mode_q;
  logic [MAX_LEN-2:0] hist_q;
  logic [LEN_W-1:0]   fill_q;

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   len_m1;
  logic               window_match;
  logic               bit_accept;

  // len_q is never zero, so len_m1 cannot wrap.
  assign window     = {hist_q, bit_in};
  assign len_m1     = len_q - LEN_W'(1);
  assign bit_accept = bit_valid & ~cfg_load & ~rst;

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
  end

  assign window_match = (((window ^ pattern_q) & len_mask) == '0);
  assign detect       = bit_accept & (fill_q == len_m1) & window_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= MAX_LEN'(DEFAULT_PATTERN);
      len_q     <= LEN_W'(clamp_len(DEFAULT_LEN, MAX_LEN));
      mode_q    <= match_mode_e'(DEFAULT_OVERLAP);
    end else if (cfg_load) begin
      pattern_q <= cfg_pattern;
      len_q     <= LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
      mode_q    <= match_mode_e'(cfg_overlap);
    end
  end

  // A disjoint-mode hit restarts the fill so the next match needs a full set of fresh bits.
  always_ff @(posedge clk) begin
    if (rst || cfg_load) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (bit_valid) begin
      hist_q <= window[MAX_LEN-2:0];
      if (detect && (mode_q == MODE_DISJOINT)) begin
        fill_q <= '0;
      end else if (fill_q != len_m1) begin
        fill_q <= fill_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      detect_q <= 1'b0;
    end else begin
      detect_q <= detect;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (count_clr),
    .inc  (detect),
    .count(match_count)
  );

endmodule

// File: tb/tb_seq_detector_prog.sv
// Table-driven bench for seq_detector_prog: one record per clock cycle with
// hand-computed detect and post-edge match_count values.
module tb_seq_detector_prog;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned LEN_W   = 4;

  typedef struct {
    logic             rst;
    logic             load;
    logic [7:0]       pat;
    logic [3:0]       len;
    logic             ovl;
    logic             valid;
    logic             bin;
    logic             clr;
    logic             expDetect;
    logic [CNT_W-1:0] expCount;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               bit_valid = 1'b0;
  logic               bit_in = 1'b0;
  logic               count_clr = 1'b0;
  logic               detect;
  logic               detect_q;
  logic [CNT_W-1:0]   match_count;

  vec_t vecs[$];
  int   compared = 0;
  int   mismatched = 0;

  seq_detector_prog #(
    .MAX_LEN(MAX_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .count_clr  (count_clr),
    .detect     (detect),
    .detect_q   (detect_q),
    .match_count(match_count)
  );

  always #5 clk = ~clk;

  task automatic addVec(input logic r, input logic ld, input logic [7:0] p, input logic [3:0] l,
                        input logic o, input logic v, input logic b, input logic c,
                        input logic det, input logic [CNT_W-1:0] cnt);
    vec_t x;
    x.rst = r; x.load = ld; x.pat = p; x.len = l; x.ovl = o;
    x.valid = v; x.bin = b; x.clr = c; x.expDetect = det; x.expCount = cnt;
    vecs.push_back(x);
  endtask

  task automatic bitVec(input logic b, input logic det, input logic [CNT_W-1:0] cnt);
    addVec(0, 0, 8'h00, 4'd0, 0, 1, b, 0, det, cnt);
  endtask

  task automatic gapVec(input int n, input logic [CNT_W-1:0] cnt);
    for (int i = 0; i < n; i++) addVec(0, 0, 8'h00, 4'd0, 0, 0, 1, 0, 0, cnt);
  endtask

  task automatic applyStimulus(input vec_t x);
    rst         = x.rst;
    cfg_load    = x.load;
    cfg_pattern = x.pat;
    cfg_len     = x.len;
    cfg_overlap = x.ovl;
    bit_valid   = x.valid;
    bit_in      = x.bin;
    count_clr   = x.clr;
  endtask

  task automatic checkOutput(input string name, input int idx, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s vec %0d: got %0d, expected %0d", name, idx, actual, expected);
    end
  endtask

  initial begin
    // Defaults after reset, disjoint mode: 11011011 hits on bit 5 only.
    addVec(1, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 2'd0);
    bitVec(1, 0, 0); bitVec(1, 0, 0); bitVec(0, 0, 0); bitVec(1, 0, 0);
    bitVec(1, 1, 1); bitVec(0, 0, 1); bitVec(1, 0, 1); bitVec(1, 0, 1);

    // Clear, then load 11011 overlapping with a valid bit that must be discarded.
    addVec(0, 0, 8'h00, 4'd0, 0, 0, 0, 1, 0, 2'd0);
    addVec(0, 1, 8'b0001_1011, 4'd5, 1, 1, 1, 0, 0, 2'd0);
    bitVec(1, 0, 0); bitVec(1, 0, 0); bitVec(0, 0, 0); bitVec(1, 0, 0);
    bitVec(1, 1, 1); bitVec(0, 0, 1); bitVec(1, 0, 1); bitVec(1, 1, 2);

    // Reset restores defaults; gaps between valid bits are transparent.
    addVec(1, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 2'd0);
    bitVec(1, 0, 0); gapVec(3, 0);
    bitVec(1, 0, 0); gapVec(3, 0);
    bitVec(0, 0, 0); gapVec(3, 0);
    bitVec(1, 0, 0); gapVec(3, 0);
    bitVec(1, 1, 1); gapVec(3, 1);

    // 101 disjoint: 10101 hits on bit 3 only.
    addVec(0, 1, 8'b0000_0101, 4'd3, 0, 0, 0, 1, 0, 2'd0);
    bitVec(1, 0, 0); bitVec(0, 0, 0); bitVec(1, 1, 1); bitVec(0, 0, 1); bitVec(1, 0, 1);

    // len=0 clamps to 1 with pattern bit0=1.
    addVec(0, 1, 8'b0000_0001, 4'd0, 0, 0, 0, 1, 0, 2'd0);
    bitVec(1, 1, 1); bitVec(0, 0, 1); bitVec(1, 1, 2);

    // len=1 overlapping, six 1s saturate the 2-bit counter; clear coincident with detect gives 1.
    addVec(0, 1, 8'b0000_0001, 4'd1, 1, 0, 0, 1, 0, 2'd0);
    bitVec(1, 1, 1); bitVec(1, 1, 2); bitVec(1, 1, 3);
    bitVec(1, 1, 3); bitVec(1, 1, 3); bitVec(1, 1, 3);
    addVec(0, 0, 8'h00, 4'd0, 0, 1, 1, 1, 1, 2'd1);
    addVec(0, 0, 8'h00, 4'd0, 0, 0, 0, 1, 0, 2'd0);

    // len=15 clamps to MAX_LEN=8: full-width pattern 10110011.
    addVec(0, 1, 8'b1011_0011, 4'd15, 0, 0, 0, 0, 0, 2'd0);
    bitVec(1, 0, 0); bitVec(0, 0, 0); bitVec(1, 0, 0); bitVec(1, 0, 0);
    bitVec(0, 0, 0); bitVec(0, 0, 0); bitVec(1, 0, 0); bitVec(1, 1, 1);

    // Reset mid-sequence: the bit presented with rst would complete 101 but is dropped.
    addVec(0, 1, 8'b0000_0101, 4'd3, 0, 0, 0, 0, 0, 2'd1);
    bitVec(1, 0, 1); bitVec(0, 0, 1);
    addVec(1, 0, 8'h00, 4'd0, 0, 1, 1, 0, 0, 2'd0);
    bitVec(1, 0, 0); bitVec(1, 0, 0); bitVec(0, 0, 0); bitVec(1, 0, 0); bitVec(1, 1, 1);
    bitVec(0, 0, 1);

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #2;
      checkOutput("detect", i, int'(detect), int'(vecs[i].expDetect));
      @(posedge clk);
      #1;
      checkOutput("detect_q", i, int'(detect_q), int'(vecs[i].expDetect));
      checkOutput("match_count", i, int'(match_count), int'(vecs[i].expCount));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
